// File: rtl/bus_select_arbiter_pkg.sv
// Shared constants for the bus select arbiter: source indices, arbitration modes
// and the default build sizes.
package bus_select_arbiter_pkg;

  localparam int DEFAULT_N     = 24;
  localparam int DEFAULT_SEL_W = 5;
  localparam int DEFAULT_CNT_W = 8;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mode_e;

  localparam int SRC_R0     = 0;
  localparam int SRC_R1     = 1;
  localparam int SRC_R2     = 2;
  localparam int SRC_R3     = 3;
  localparam int SRC_R4     = 4;
  localparam int SRC_R5     = 5;
  localparam int SRC_R6     = 6;
  localparam int SRC_R7     = 7;
  localparam int SRC_R8     = 8;
  localparam int SRC_R9     = 9;
  localparam int SRC_R10    = 10;
  localparam int SRC_R11    = 11;
  localparam int SRC_R12    = 12;
  localparam int SRC_R13    = 13;
  localparam int SRC_R14    = 14;
  localparam int SRC_R15    = 15;
  localparam int SRC_HI     = 16;
  localparam int SRC_LO     = 17;
  localparam int SRC_ZHI    = 18;
  localparam int SRC_ZLO    = 19;
  localparam int SRC_PC     = 20;
  localparam int SRC_MDR    = 21;
  localparam int SRC_INPORT = 22;
  localparam int SRC_COUT   = 23;

endpackage

// File: rtl/bus_select_arbiter_prio_find.sv
// Combinational finder: first set bit of vec at or above start, wrapping N-1 -> 0.
// start must be below N.
module prio_find #(
  parameter int N     = 24,
  parameter int SEL_W = 5
) (
  input  logic [N-1:0]     vec,
  input  logic [SEL_W-1:0] start,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  int pos;

  // Walk offsets from the far end back toward start so the nearest hit wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    pos   = 0;
    for (int k = N - 1; k >= 0; k--) begin
      pos = int'(start) + k;
      if (pos >= N) pos = pos - N;
      if (vec[pos]) begin
        found = 1'b1;
        idx   = SEL_W'(pos);
      end
    end
  end

endmodule

// File: rtl/bus_select_arbiter.sv
// Registered bus select arbiter: fixed-priority or round-robin grant with lock,
// multi-driver conflict flag and saturating conflict counter.
module bus_select_arbiter
  import bus_select_arbiter_pkg::*;
#(
  parameter int N     = DEFAULT_N,
  parameter int SEL_W = DEFAULT_SEL_W,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clock,
  input  logic             clear,
  input  logic [N-1:0]     req,
  input  logic             mode,
  input  logic             lock,
  output logic [SEL_W-1:0] sel_out,
  output logic             sel_valid,
  output logic             conflict,
  output logic [CNT_W-1:0] conflict_count,
  output logic [SEL_W-1:0] rr_ptr
);

  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(N - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic             rr_mode;
  logic             hold;
  logic             multi;
  logic             found;
  logic [N-1:0]     req_rev;
  logic [N-1:0]     search_vec;
  logic [SEL_W-1:0] search_start;
  logic [SEL_W-1:0] idx;
  logic [SEL_W-1:0] grant;
  logic [SEL_W-1:0] next_ptr;

  // Fixed priority reuses the wrap finder: reversing req turns "highest index"
  // into "first set bit from 0".
  for (genvar i = 0; i < N; i++) begin : g_rev
    assign req_rev[i] = req[N-1-i];
  end

  assign rr_mode      = (mode == MODE_RR);
  assign search_vec   = rr_mode ? req : req_rev;
  assign search_start = rr_mode ? rr_ptr : '0;

  prio_find #(
    .N     (N),
    .SEL_W (SEL_W)
  ) u_prio_find (
    .vec   (search_vec),
    .start (search_start),
    .found (found),
    .idx   (idx)
  );

  assign grant    = rr_mode ? idx : (LAST_IDX - idx);
  assign next_ptr = (grant == LAST_IDX) ? '0 : (grant + SEL_W'(1));
  assign multi    = |(req & (req - N'(1)));
  assign hold     = lock && sel_valid;

  always_ff @(posedge clock) begin
    if (!clear) begin
      sel_out        <= '0;
      sel_valid      <= 1'b0;
      conflict       <= 1'b0;
      conflict_count <= '0;
      rr_ptr         <= '0;
    end else begin
      conflict <= multi;
      if (multi && (conflict_count != CNT_MAX)) begin
        conflict_count <= conflict_count + CNT_W'(1);
      end

      if (hold) begin
        sel_out   <= sel_out;
        sel_valid <= sel_valid;
        rr_ptr    <= rr_ptr;
      end else if (found) begin
        sel_out   <= grant;
        sel_valid <= 1'b1;
        if (rr_mode) rr_ptr <= next_ptr;
      end else begin
        sel_out   <= '0;
        sel_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/bus_select_arbiter.md
Name: bus_select_arbiter

Overview:
- Parametrised, registered successor to the bus select encoder.
- Turns N per-source drive-enable requests into a binary select code for the shared-bus multiplexer.
- Supports two arbitration modes: fixed priority (highest index wins) and round-robin.
- Adds lock/hold of the current grant, multi-driver conflict detection and a saturating conflict counter.
- Sits between control-unit out-enables and the bus mux; the select code is registered, so bus data is valid one cycle after request.

Parameters:
- N, 24, number of bus sources (legal range 2..32); index order is r0..r15, HI, LO, Z_HI, Z_LO, PC, MDR, InPort, Cout for the default build.
- SEL_W, 5, select width; must equal ceil(log2(N)).
- CNT_W, 8, conflict counter width.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- clear  in  1  synchronous reset, active-low; sampled on rising edge of clock.
- req  in  N  drive-enable requests, bit i = source i wants the bus.
- mode  in  1  0 = fixed priority, 1 = round-robin.
- lock  in  1  hold current grant while 1.
- sel_out  out  SEL_W  registered select code for bus mux.
- sel_valid  out  1  registered; 1 when sel_out reflects a granted source.
- conflict  out  1  registered one-cycle pulse; more than one req bit was set in the previous cycle.
- conflict_count  out  CNT_W  saturating count of cycles with conflict.
- rr_ptr  out  SEL_W  current round-robin start index (debug/observability).

Behaviour:
- Reset (clear=0 at a rising edge): sel_out=0, sel_valid=0, conflict=0, conflict_count=0, rr_ptr=0.
- Reset wins over every other input, including lock and in-progress grants.
- Latency: the grant for req sampled at edge k appears on sel_out/sel_valid after edge k. It is combinationally stable from then until edge k+1.
- Fixed mode (mode=0):
  - Grant the highest index i with req[i]=1.
  - rr_ptr is not modified.
- Round-robin mode (mode=1):
  - Search upward from index rr_ptr, wrapping N-1 -> 0; the first set bit wins.
  - After each granted cycle (sel_valid becomes/stays 1 and lock inactive), rr_ptr <= grant+1, wrapping to 0 when grant=N-1.
- No request (req=0, lock inactive): sel_valid <= 0 and sel_out <= 0. rr_ptr holds.
- Lock:
  - If lock=1 and sel_valid=1 at an edge, sel_out, sel_valid and rr_ptr hold. This applies even if the held source deasserts its req or a higher-priority request appears.
  - lock=1 with sel_valid=0 has no effect; normal arbitration occurs.
  - A grant obtained in the same edge is not locked until the next edge.
- Mode change: takes effect at the next edge's arbitration. rr_ptr is preserved across mode switches.
- Conflict:
  - conflict <= 1 iff popcount(req) >= 2 at the edge. This is evaluated regardless of lock or mode.
  - conflict_count increments on each such edge and saturates at 2^CNT_W-1 (no wrap).
  - Cleared only by reset.
- Out-of-range bits: rr_ptr never holds a value >= N. Select codes >= N are never produced.
- Simultaneous lock release and new requests: the edge where lock has dropped to 0 arbitrates normally from the current rr_ptr.

Decomposition:
- Shared package holds:
  - the source index constants (SRC_R0..SRC_R15=0..15, SRC_HI=16, SRC_LO=17, SRC_ZHI=18, SRC_ZLO=19, SRC_PC=20, SRC_MDR=21, SRC_INPORT=22, SRC_COUT=23);
  - MODE_FIXED=0 and MODE_RR=1;
  - the default N/SEL_W values.
- One sub-module: prio_find, a combinational parametrised "first set bit at or above start index, with wrap" finder. Used for round-robin with start=rr_ptr, and for fixed mode by bit-reversal with start=0.
- Counter and registers stay in the top.

Test Plan:
- Reset/idle: clear=0 for 2 edges, then req=0 -> sel_out=0, sel_valid=0, conflict=0, conflict_count=0, rr_ptr=0.
- Fixed priority, mode=0: req bits 3, 21, 23 set -> next edge sel_out=23 (Cout), sel_valid=1, conflict=1, conflict_count=1. Then req bit 5 only -> sel_out=5, conflict=0.
- Round-robin, mode=1, rr_ptr=0: req bits 2, 7, 20 held for 4 edges -> sel_out sequence 2, 7, 20, 2; rr_ptr sequence 3, 8, 21, 3; conflict_count +4.
- Lock: grant sel_out=7, then lock=1 with req switched to bit 23 only for 3 edges -> sel_out stays 7, sel_valid=1, rr_ptr frozen. Drop lock -> next edge sel_out=23.
- Saturation and mid-operation reset: CNT_W=2, hold req bits 0 and 1 for 5 edges -> conflict_count 1, 2, 3, 3, 3. Assert clear=0 while lock=1 and sel_valid=1 -> all outputs 0 after that edge.
- Wrap and parameter sweep: N=5, SEL_W=3, mode=1. Grant index 4 -> rr_ptr=0. req bits 4 and 0 -> next grant 0. Confirm sel_out is never >= 5 over 10k random cycles.
